phase_clock_gen: RTL and testbench

- Parametrised multi-phase, non-overlapping clock generator; next generation of the MCS8 two-phase (clk1/clk2) generator.
- Produces NPHASE one-hot phase pulses with programmable prescale, pulse width and inter-phase gap, plus a cycle-start strobe.
- Supports clean start/stop on cycle boundaries.
- Sits in bench_top/core wrapper between the system clock and the CPU phase inputs.

---
 rtl/phase_clock_gen_if.sv | 67 ++++++
 rtl/phase_clock_gen.sv | 253 +++++++++++++++++++++++++
 tb/tb_phase_clock_gen.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/phase_clock_gen_if.sv
// -----------------------------------------------------------------------------
// phase_clock_gen_if
//   Bundles the run control and phase outputs of phase_clock_gen.
//
//   Optional build macro: PHASE_CLOCK_STEP_EN adds the STEP_I single-cycle
//   request line.
//
//   Signals:
//     EN_I     run request (consumer -> generator)
//     STEP_I   single-cycle request (only with PHASE_CLOCK_STEP_EN)
//     PHASE_O  NPHASE registered phase pulses, one-hot or zero
//     IDX_O    current/last phase slot index
//     SYNC_O   one-clock strobe at the start of every cycle
//     BUSY_O   high whenever the generator is not idle
//
//   Modports:
//     master  generator side (drives phase outputs)
//     slave   consumer side (drives run control)
// -----------------------------------------------------------------------------
interface phase_clock_gen_if #(
  parameter int unsigned NPHASE = 2
);
  logic              EN_I;
`ifdef PHASE_CLOCK_STEP_EN
  logic              STEP_I;
`endif
  logic [NPHASE-1:0] PHASE_O;
  logic [2:0]        IDX_O;
  logic              SYNC_O;
  logic              BUSY_O;

`ifdef PHASE_CLOCK_STEP_EN
  modport master (
    input  EN_I,
    input  STEP_I,
    output PHASE_O,
    output IDX_O,
    output SYNC_O,
    output BUSY_O
  );

  modport slave (
    output EN_I,
    output STEP_I,
    input  PHASE_O,
    input  IDX_O,
    input  SYNC_O,
    input  BUSY_O
  );
`else
  modport master (
    input  EN_I,
    output PHASE_O,
    output IDX_O,
    output SYNC_O,
    output BUSY_O
  );

  modport slave (
    output EN_I,
    input  PHASE_O,
    input  IDX_O,
    input  SYNC_O,
    input  BUSY_O
  );
`endif
endinterface

// File: rtl/phase_clock_gen.sv
// -----------------------------------------------------------------------------
// phase_clock_gen
//   Multi-phase, non-overlapping clock generator. Emits NPHASE one-hot phase
//   pulses in sequence. Each slot is GAP ticks of all-low followed by PULSE
//   ticks with PHASE_O[idx] high; a tick is PRESCALE system clocks.
//   Cycle length = NPHASE*(GAP+PULSE)*PRESCALE clocks. The default build
//   (2,1,1,1) reproduces the legacy clk1/clk2 pattern 00,01,00,10.
//
//   Optional build macro: PHASE_CLOCK_STEP_EN
//     Adds STEP_I: in IDLE with EN_I=0, STEP_I=1 runs exactly one full cycle
//     and then returns to IDLE regardless of EN_I. Ignored while busy; EN_I
//     has priority.
//
//   Ports:
//     CLK_I   system clock, all logic on posedge
//     RST_I   synchronous reset, active-high, dominant
//     bus     phase_clock_gen_if.master (EN_I, [STEP_I], PHASE_O, IDX_O,
//             SYNC_O, BUSY_O)
// -----------------------------------------------------------------------------
module phase_clock_gen #(
  parameter int unsigned NPHASE   = 2,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned PRESCALE = 1,
  parameter int unsigned PULSE    = 1,
  parameter int unsigned GAP      = 1
) (
  input  logic              CLK_I,
  input  logic              RST_I,
  phase_clock_gen_if.master bus
);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter checks: a bad build stops immediately.
  // ---------------------------------------------------------------------------
  localparam longint unsigned CNT_MAX = (64'd1 << CNT_W) - 64'd1;

  if (NPHASE < 2 || NPHASE > 8) begin : g_bad_nphase
    $fatal(1, "phase_clock_gen: NPHASE=%0d outside 2..8", NPHASE);
  end
  if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
    $fatal(1, "phase_clock_gen: CNT_W=%0d outside 1..32", CNT_W);
  end
  if (PRESCALE < 1 || longint'(PRESCALE) > CNT_MAX) begin : g_bad_prescale
    $fatal(1, "phase_clock_gen: PRESCALE=%0d out of range", PRESCALE);
  end
  if (PULSE < 1 || longint'(PULSE) > CNT_MAX) begin : g_bad_pulse
    $fatal(1, "phase_clock_gen: PULSE=%0d out of range", PULSE);
  end
  if (GAP < 1 || longint'(GAP) > CNT_MAX) begin : g_bad_gap
    $fatal(1, "phase_clock_gen: GAP=%0d out of range", GAP);
  end

  // ---------------------------------------------------------------------------
  // Constants
  // ---------------------------------------------------------------------------
  localparam logic [CNT_W-1:0] PRE_LAST   = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE - 1);
  localparam logic [2:0]       IDX_LAST   = 3'(NPHASE - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GAP,
    ST_PULSE
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  pre_q,   pre_d;    // clocks within the current tick
  logic [CNT_W-1:0]  cnt_q,   cnt_d;    // ticks within the current GAP/PULSE
  logic [2:0]        idx_q,   idx_d;
  logic [NPHASE-1:0] phase_q, phase_d;
  logic              sync_q,  sync_d;

  // ---------------------------------------------------------------------------
  // Run-request decode
  //   start_run    : leave IDLE on this edge
  //   continue_run : at the wrap, begin another cycle instead of going idle
  // ---------------------------------------------------------------------------
  logic start_run;
  logic continue_run;

`ifdef PHASE_CLOCK_STEP_EN
  // Set when the current cycle was launched by STEP_I alone; forces a return
  // to IDLE at the wrap whatever EN_I is doing by then.
  logic step_mode_q, step_mode_d;
  logic step_only;

  assign step_only    = bus.STEP_I && !bus.EN_I;
  assign start_run    = bus.EN_I || bus.STEP_I;
  assign continue_run = bus.EN_I && !step_mode_q;
`else
  assign start_run    = bus.EN_I;
  assign continue_run = bus.EN_I;
`endif

  // ---------------------------------------------------------------------------
  // Tick and segment-end events
  // ---------------------------------------------------------------------------
  logic tick;
  logic gap_done;
  logic pulse_done;
  logic last_slot;

  assign tick       = (pre_q == PRE_LAST);
  assign gap_done   = (state_q == ST_GAP)   && tick && (cnt_q == GAP_LAST);
  assign pulse_done = (state_q == ST_PULSE) && tick && (cnt_q == PULSE_LAST);
  assign last_slot  = (idx_q == IDX_LAST);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q <= ST_IDLE;
      pre_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      phase_q <= '0;
      sync_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      phase_q <= phase_d;
      sync_q  <= sync_d;
    end
  end

`ifdef PHASE_CLOCK_STEP_EN
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      step_mode_q <= 1'b0;
    end else begin
      step_mode_q <= step_mode_d;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic: FSM state, prescaler and segment counter
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    cnt_d   = cnt_q;
`ifdef PHASE_CLOCK_STEP_EN
    step_mode_d = step_mode_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        pre_d = '0;
        cnt_d = '0;
        if (start_run) begin
          state_d = ST_GAP;
`ifdef PHASE_CLOCK_STEP_EN
          step_mode_d = step_only;
`endif
        end
      end

      ST_GAP: begin
        pre_d = tick ? '0 : pre_q + 1'b1;
        if (tick) begin
          if (gap_done) begin
            cnt_d   = '0;
            state_d = ST_PULSE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      ST_PULSE: begin
        pre_d = tick ? '0 : pre_q + 1'b1;
        if (tick) begin
          if (pulse_done) begin
            cnt_d = '0;
            if (!last_slot || continue_run) begin
              state_d = ST_GAP;
            end else begin
              state_d = ST_IDLE;
            end
`ifdef PHASE_CLOCK_STEP_EN
            if (last_slot) begin
              step_mode_d = 1'b0;
            end
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        pre_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic: registered phase pulses, slot index and cycle strobe
  // ---------------------------------------------------------------------------
  always_comb begin
    phase_d = phase_q;
    idx_d   = idx_q;
    sync_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        phase_d = '0;
        idx_d   = '0;
        sync_d  = start_run;
      end

      ST_GAP: begin
        phase_d = '0;
        if (gap_done) begin
          phase_d = NPHASE'(1) << idx_q;
        end
      end

      ST_PULSE: begin
        if (pulse_done) begin
          phase_d = '0;
          if (last_slot) begin
            idx_d  = '0;
            sync_d = continue_run;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end

      default: begin
        phase_d = '0;
        idx_d   = '0;
      end
    endcase
  end

  assign bus.PHASE_O = phase_q;
  assign bus.IDX_O   = idx_q;
  assign bus.SYNC_O  = sync_q;
  assign bus.BUSY_O  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_phase_clock_gen.sv
// -----------------------------------------------------------------------------
// tb_phase_clock_gen
//   Scoreboard bench for phase_clock_gen. Two instances: dut_a at the default
//   parameters and dut_b at NPHASE=4, PULSE=2, GAP=3, PRESCALE=2. The
//   stimulus process drives inputs on the falling edge and pushes the output
//   expected after the following rising edge; the monitor pops and compares
//   shortly after every rising edge.
// -----------------------------------------------------------------------------
module tb_phase_clock_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a;
  logic rst_b;
  logic step_a;

  phase_clock_gen_if #(.NPHASE(2)) bus_a ();
  phase_clock_gen_if #(.NPHASE(4)) bus_b ();

`ifdef PHASE_CLOCK_STEP_EN
  assign bus_a.STEP_I = step_a;
  assign bus_b.STEP_I = 1'b0;
`endif

  phase_clock_gen #(
    .NPHASE   (2),
    .CNT_W    (8),
    .PRESCALE (1),
    .PULSE    (1),
    .GAP      (1)
  ) dut_a (
    .CLK_I (clk),
    .RST_I (rst_a),
    .bus   (bus_a.master)
  );

  phase_clock_gen #(
    .NPHASE   (4),
    .CNT_W    (8),
    .PRESCALE (2),
    .PULSE    (2),
    .GAP      (3)
  ) dut_b (
    .CLK_I (clk),
    .RST_I (rst_b),
    .bus   (bus_b.master)
  );

  typedef struct {
    bit         sel;     // 0 = dut_a, 1 = dut_b
    logic [7:0] phase;
    logic [2:0] idx;
    logic       sync;
    logic       busy;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  exp_t       m_e;
  logic [7:0] m_phase;
  logic [2:0] m_idx;
  logic       m_sync;
  logic       m_busy;

  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      m_e = sb.pop_front();
      if (!m_e.sel) begin
        m_phase = 8'(bus_a.PHASE_O);
        m_idx   = bus_a.IDX_O;
        m_sync  = bus_a.SYNC_O;
        m_busy  = bus_a.BUSY_O;
      end else begin
        m_phase = 8'(bus_b.PHASE_O);
        m_idx   = bus_b.IDX_O;
        m_sync  = bus_b.SYNC_O;
        m_busy  = bus_b.BUSY_O;
      end
      checks++;
      if ({m_phase, m_idx, m_sync, m_busy} !== {m_e.phase, m_e.idx, m_e.sync, m_e.busy}) begin
        errors++;
        $display("FAIL %s @%0t: got phase=%b idx=%0d sync=%b busy=%b, expected phase=%b idx=%0d sync=%b busy=%b",
                 m_e.name, $time, m_phase, m_idx, m_sync, m_busy,
                 m_e.phase, m_e.idx, m_e.sync, m_e.busy);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Expected-value helpers
  // ---------------------------------------------------------------------------
  function automatic exp_t mk(input bit sel, input logic [7:0] phase,
                              input logic [2:0] idx, input logic sync,
                              input logic busy, input string name);
    exp_t e;
    e.sel   = sel;
    e.phase = phase;
    e.idx   = idx;
    e.sync  = sync;
    e.busy  = busy;
    e.name  = name;
    return e;
  endfunction

  // Expected output k edges after the start edge of a free-running sequence
  // (k=0 is the start edge itself), derived from the slot timing formula.
  function automatic exp_t run_exp(input bit sel, input int np, input int g,
                                   input int p, input int ps, input int k,
                                   input string name);
    int slot_len;
    int o;
    int slot;
    int w;
    exp_t e;
    slot_len = (g + p) * ps;
    o        = k % (np * slot_len);
    slot     = o / slot_len;
    w        = o % slot_len;
    e.sel    = sel;
    e.phase  = (w >= g * ps) ? (8'd1 << slot) : 8'd0;
    e.idx    = 3'(slot);
    e.sync   = (o == 0);
    e.busy   = 1'b1;
    e.name   = name;
    return e;
  endfunction

  // Drive one DUT's inputs for the next rising edge and queue the response.
  task automatic drive(input bit sel, input logic rst, input logic en,
                       input logic stp, input exp_t e);
    if (!sel) begin
      rst_a     = rst;
      bus_a.EN_I = en;
      step_a    = stp;
    end else begin
      rst_b     = rst;
      bus_b.EN_I = en;
    end
    sb.push_back(e);
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    rst_a      = 1'b1;
    rst_b      = 1'b1;
    step_a     = 1'b0;
    bus_a.EN_I = 1'b0;
    bus_b.EN_I = 1'b0;
    @(negedge clk);

    // Reset held three clocks
    for (int i = 0; i < 3; i++) drive(0, 1, 0, 0, mk(0, 8'h00, 3'd0, 0, 0, "t1_reset"));

    // EN_I low after reset: nothing happens
    for (int i = 0; i < 6; i++) drive(0, 0, 0, 0, mk(0, 8'h00, 3'd0, 0, 0, "t5_idle"));

    // Free run at defaults: 00,01,00,10 with SYNC on the first 00
    for (int k = 0; k < 20; k++) drive(0, 0, 1, 0, run_exp(0, 2, 1, 1, 1, k, "t1_run"));

    // EN_I dropped from the edge where PHASE_O[0] rises: cycle still completes
    drive(0, 1, 0, 0, mk(0, 8'h00, 3'd0, 0, 0, "t3_reset"));
    drive(0, 0, 1, 0, mk(0, 8'b00, 3'd0, 1, 1, "t3_start"));
    drive(0, 0, 0, 0, mk(0, 8'b01, 3'd0, 0, 1, "t3_p0"));
    drive(0, 0, 0, 0, mk(0, 8'b00, 3'd1, 0, 1, "t3_gap1"));
    drive(0, 0, 0, 0, mk(0, 8'b10, 3'd1, 0, 1, "t3_p1"));
    for (int i = 0; i < 5; i++) drive(0, 0, 0, 0, mk(0, 8'h00, 3'd0, 0, 0, "t3_idle"));

    // Reset while PHASE_O[1] is high, then restart
    for (int k = 0; k < 4; k++) drive(0, 0, 1, 0, run_exp(0, 2, 1, 1, 1, k, "t4_run"));
    drive(0, 1, 1, 0, mk(0, 8'h00, 3'd0, 0, 0, "t4_reset_mid_pulse"));
    for (int k = 0; k < 9; k++) drive(0, 0, 1, 0, run_exp(0, 2, 1, 1, 1, k, "t4_restart"));

`ifdef PHASE_CLOCK_STEP_EN
    // Single step, mid-cycle step ignored, EN_I at the wrap does not extend
    drive(0, 1, 0, 0, mk(0, 8'h00, 3'd0, 0, 0, "t6_reset"));
    drive(0, 0, 0, 0, mk(0, 8'h00, 3'd0, 0, 0, "t6_idle"));
    drive(0, 0, 0, 1, mk(0, 8'b00, 3'd0, 1, 1, "t6_step_start"));
    drive(0, 0, 0, 0, mk(0, 8'b01, 3'd0, 0, 1, "t6_p0"));
    drive(0, 0, 0, 1, mk(0, 8'b00, 3'd1, 0, 1, "t6_gap1_step_ignored"));
    drive(0, 0, 0, 0, mk(0, 8'b10, 3'd1, 0, 1, "t6_p1"));
    drive(0, 0, 1, 0, mk(0, 8'h00, 3'd0, 0, 0, "t6_end_idle"));
    // EN_I and STEP_I together: EN_I wins, so the run continues past the wrap
    drive(0, 0, 1, 1, run_exp(0, 2, 1, 1, 1, 0, "t6_en_prio"));
    for (int k = 1; k < 5; k++) drive(0, 0, 1, 0, run_exp(0, 2, 1, 1, 1, k, "t6_en_run"));
    for (int k = 5; k < 8; k++) drive(0, 0, 0, 0, run_exp(0, 2, 1, 1, 1, k, "t6_en_drain"));
    drive(0, 0, 0, 0, mk(0, 8'h00, 3'd0, 0, 0, "t6_final_idle"));
    drive(0, 0, 0, 1, mk(0, 8'b00, 3'd0, 1, 1, "t6_step_again"));
    drive(0, 0, 0, 0, mk(0, 8'b01, 3'd0, 0, 1, "t6_again_p0"));
`endif

    // Park dut_a in reset (unchecked) while dut_b runs
    rst_a      = 1'b1;
    bus_a.EN_I = 1'b0;
    step_a     = 1'b0;

    // dut_b: NPHASE=4, GAP=3, PULSE=2, PRESCALE=2 -> 40-clock cycle
    for (int i = 0; i < 2; i++) drive(1, 1, 0, 0, mk(1, 8'h00, 3'd0, 0, 0, "t2_reset"));
    for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, mk(1, 8'h00, 3'd0, 0, 0, "t2_idle"));
    for (int k = 0; k < 45; k++) drive(1, 0, 1, 0, run_exp(1, 4, 3, 2, 2, k, "t2_run"));
    for (int k = 45; k < 80; k++) drive(1, 0, 0, 0, run_exp(1, 4, 3, 2, 2, k, "t2_drain"));
    for (int i = 0; i < 4; i++) drive(1, 0, 0, 0, mk(1, 8'h00, 3'd0, 0, 0, "t2_end_idle"));

    // Let the monitor consume anything still queued
    for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
